dpram_rd_arbiter: RTL and testbench
===================================

# dpram_rd_arbiter

Read-port arbiter and burst sequencer for a dual-port RAM in the graphics pipeline. It shares the single RAM read port, in the rd_clk domain, between N_REQ requesters such as scanline fetch and sprite fetch. Each requester asks for a burst of consecutive words. The block grants requesters round-robin, drives the RAM read address one word per cycle, and routes returned data back to the owner with valid and last flags.

## Interface
- N_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 8, RAM word width
- DATA_N, 16, RAM depth in words; need not be a power of two
- ADDR_BITS, $clog2(DATA_N), RAM address width
- LEN_BITS, 4, burst-length field width; burst = req_len+1 words
- rd_clk  in  1  clock; same clock as the RAM read port
- rst  in  1  reset: synchronous, active-high
- req_valid  in  N_REQ  per-requester request
- req_addr  in  N_REQ*ADDR_BITS  start address; requester i occupies slice [i*ADDR_BITS +: ADDR_BITS]
- req_len  in  N_REQ*LEN_BITS  burst length minus one, sliced the same way
- req_ready  out  N_REQ  one-hot acceptance pulse
- resp_valid  out  N_REQ  one-hot: resp_data belongs to requester i
- resp_last  out  1  current response is the final word of its burst
- resp_data  out  DATA_WIDTH  returned word
- ram_rd_addr  out  ADDR_BITS  to the RAM read address; registered
- ram_rd_out  in  DATA_WIDTH  from the RAM read data; 1-cycle registered RAM read

## Operation
- FSM states are IDLE and BURST.
- Acceptance window: the state is IDLE, or the state is BURST with remaining count 0 (the last beat is being issued).
- In the acceptance window, the round-robin pick among asserted req_valid gets req_ready=1 for one cycle.
  - Search starts at pointer ptr.
  - On acceptance: ptr ← grantee+1 mod N_REQ, owner ← grantee, ram_rd_addr ← req_addr[grantee], cnt ← req_len[grantee], state ← BURST.
- BURST with cnt>0:
  - ram_rd_addr ← ram_rd_addr+1, wrapping DATA_N-1 → 0.
  - cnt ← cnt-1.
  - req_ready is all zero.
- BURST with cnt=0 and no request: state ← IDLE, and ram_rd_addr holds its value.
- Response pipeline is a 2-stage shift of {valid, owner, last}, aligned with the RAM latency.
  - resp_data = ram_rd_out, passed through combinationally.
  - resp_valid and resp_last are 0 when no beat is in flight.
- Requester rules:
  - A requester holds req_valid, req_addr and req_len stable until req_ready is seen.
  - A requester deasserts req_valid in the cycle after req_ready unless it is issuing a new request.
  - A requester must not retract a pending request.
- req_len=0 produces a single-word burst with resp_last on that word.
- resp_data is don't-care when resp_valid=0; the bench must not check it.

## Timing
- Acceptance is combinational in cycle A (req_ready in A). ram_rd_addr carries the first address in A+1, and the first response appears in A+2.
- Throughput is 1 word/cycle.
- Back-to-back bursts have no bubble: a new grant in the cycle that issues the last address puts the new start address on ram_rd_addr in the next cycle.
- A burst of req_len=L occupies ram_rd_addr for cycles A+1..A+1+L, with responses in A+2..A+2+L. resp_last is asserted in A+2+L.
- Simultaneous requests: exactly one grant per acceptance window. Losers wait, and each waits at most N_REQ-1 bursts (fairness bound).
- Reset has priority over everything, including an active burst and in-flight responses.
  - Next cycle: state=IDLE, ptr=0, cnt=0, ram_rd_addr=0.
  - Pipeline valid bits are cleared and in-flight beats are dropped.
  - req_ready=0, resp_valid=0, resp_last=0.
  - A request asserted during rst is not accepted; it is considered in the first cycle after rst deasserts.

## Structure
- Package dpram_arb_pkg holds:
  - typedef enum logic {IDLE, BURST} arb_state_t
  - typedef struct {valid, owner, last} resp_tag_t, used by the pipeline stages
- Sub-module rr_arbiter (parameter N).
  - Inputs: req, ptr, en.
  - Output: one-hot grant.
  - Purely combinational, with a rotate/priority-encode implementation.
- Top level holds the FSM, address counter with wrap, cnt, ptr and the response pipeline.
- Target size is ~150-250 lines total.

## Test plan
- Single request: req 0, addr=3, len=2, accepted in cycle A → ram_rd_addr 3,4,5 in A+1..A+3. resp_valid=0001 in A+2..A+4 with data = mem[3..5], and resp_last only in A+4.
- Wrap: DATA_N=12, addr=10, len=3 → addresses 10,11,0,1; resp_last on the word from address 1.
- Contention: all four requesters, len=0, held from reset release → grants in order 0,1,2,3,0, one per cycle, with no idle cycle on ram_rd_addr.
- Back-to-back: req 1 with len=3 while req 2 is waiting → req 2's req_ready is asserted in the cycle ram_rd_addr=start+3. Its first address follows the next cycle, and resp_valid switches 0010→0100 with no gap.
- Reset mid-burst: assert rst during beat 2 of a len=5 burst → next cycle all outputs are 0 and state is IDLE. No resp_valid appears afterward, and the next grant after release goes to requester 0 if it is requesting.
- Random soak with a memory model: multiple requesters with random len and addr; the scoreboard checks owner, data, last-flag and fairness bound.

Source files
------------

// File: rtl/dpram_rd_arbiter_pkg.sv
// Shared types for the dual-port RAM read-port arbiter.
// Owner tags are stored as an index, wide enough for up to 256 requesters.
package dpram_arb_pkg;

    localparam int OWNER_W = 8;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               last;
    } resp_tag_t;

endpackage

// File: rtl/dpram_rd_arbiter_rr.sv
// Combinational round-robin arbiter: rotate requests by ptr,
// priority-encode the lowest set bit, then rotate the index back.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [PW-1:0]  w_k;
    logic           w_any;
    logic [PW:0]    w_sum;
    logic [PW-1:0]  w_idx;

    always_comb begin
        w_dbl = {req, req} >> ptr;
        w_rot = w_dbl[N-1:0];
        w_k   = '0;
        w_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_k   = PW'(k);
                w_any = 1'b1;
            end
        end
        // ptr and k are both below N, so one subtraction folds the wrap
        w_sum = {1'b0, ptr} + {1'b0, w_k};
        if (w_sum >= (PW+1)'(N)) begin
            w_idx = PW'(w_sum - (PW+1)'(N));
        end else begin
            w_idx = w_sum[PW-1:0];
        end
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            if (en && w_any && (w_idx == PW'(i))) begin
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_rd_arbiter.sv
// Shares one RAM read port between N_REQ burst requesters, round-robin,
// issuing one address per cycle and tagging returned data with its owner.
module dpram_rd_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_N     = 16,
    parameter int ADDR_BITS  = $clog2(DATA_N),
    parameter int LEN_BITS   = 4
) (
    input  logic                          rd_clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ADDR_BITS-1:0]    req_addr,
    input  logic [N_REQ*LEN_BITS-1:0]     req_len,
    output logic [N_REQ-1:0]              req_ready,
    output logic [N_REQ-1:0]              resp_valid,
    output logic                          resp_last,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ADDR_BITS-1:0]          ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]         ram_rd_out
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        w_ptr_nxt;
    logic [LEN_BITS-1:0]  r_cnt;
    logic [LEN_BITS-1:0]  w_cnt_nxt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS-1:0] w_addr_nxt;
    logic [OWNER_W-1:0]   r_owner;
    logic [OWNER_W-1:0]   w_owner_nxt;
    resp_tag_t            r_s1;
    resp_tag_t            r_s2;
    resp_tag_t            w_tag;

    logic                 w_window;
    logic                 w_en;
    logic [N_REQ-1:0]     w_gnt;
    logic                 w_accept;
    logic [PW-1:0]        w_gidx;
    logic [ADDR_BITS-1:0] w_sel_addr;
    logic [LEN_BITS-1:0]  w_sel_len;
    logic [ADDR_BITS-1:0] w_addr_inc;

    assign w_window = (r_state == IDLE) || (r_cnt == '0);
    assign w_en     = w_window && !rst;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req (req_valid),
        .ptr (r_ptr),
        .en  (w_en),
        .gnt (w_gnt)
    );

    assign w_accept = |w_gnt;

    always_comb begin
        w_gidx     = '0;
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gidx     = PW'(i);
                w_sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
                w_sel_len  = req_len[i*LEN_BITS +: LEN_BITS];
            end
        end
    end

    assign w_addr_inc = (r_addr == ADDR_BITS'(DATA_N - 1)) ?
                        '0 : r_addr + ADDR_BITS'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_owner_nxt = r_owner;
        w_tag       = '0;
        case (r_state)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            BURST: begin
                if (r_cnt != '0) begin
                    w_addr_nxt  = w_addr_inc;
                    w_cnt_nxt   = r_cnt - LEN_BITS'(1);
                    w_tag.valid = 1'b1;
                    w_tag.owner = r_owner;
                    w_tag.last  = (r_cnt == LEN_BITS'(1));
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // a grant only happens in the window, so it overrides the tail beat
        if (w_accept) begin
            w_state_nxt = BURST;
            w_ptr_nxt   = (w_gidx == PW'(N_REQ - 1)) ?
                          '0 : w_gidx + PW'(1);
            w_owner_nxt = OWNER_W'(w_gidx);
            w_addr_nxt  = w_sel_addr;
            w_cnt_nxt   = w_sel_len;
            w_tag.valid = 1'b1;
            w_tag.owner = OWNER_W'(w_gidx);
            w_tag.last  = (w_sel_len == '0);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_owner <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_owner <= w_owner_nxt;
            r_s1    <= w_tag;
            r_s2    <= r_s1;
        end
    end

    assign req_ready   = w_gnt;
    assign ram_rd_addr = r_addr;
    assign resp_data   = ram_rd_out;
    assign resp_last   = r_s2.valid && r_s2.last;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = r_s2.valid && (r_s2.owner == OWNER_W'(i));
        end
    end

endmodule

// File: tb/tb_dpram_rd_arbiter.sv
// Bench for dpram_rd_arbiter: directed scenarios plus a random soak,
// checked against a cycle-indexed beat schedule and a RAM model.
module tb_dpram_rd_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int DN = 12;
    localparam int AB = 4;
    localparam int LB = 4;

    logic              rd_clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AB-1:0]   req_addr;
    logic [N*LB-1:0]   req_len;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic              resp_last;
    logic [DW-1:0]     resp_data;
    logic [AB-1:0]     ram_rd_addr;
    logic [DW-1:0]     ram_q;

    logic [DW-1:0]     mem [DN];

    dpram_rd_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .DATA_N     (DN),
        .LEN_BITS   (LB)
    ) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_last   (resp_last),
        .resp_data   (resp_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_out  (ram_q)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        if (int'(ram_rd_addr) < DN) ram_q <= mem[int'(ram_rd_addr)];
        else ram_q <= '0;
    end

    typedef struct {
        int cyc;
        int own;
        int addr;
        bit last;
    } beat_t;

    beat_t aq[$];
    beat_t rq[$];

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int mptr   = 0;
    int busy_until = -1;
    bit post_rst = 1'b0;
    bit soak = 1'b0;
    int len_max = 0;

    bit pend  [N];
    int paddr [N];
    int plen  [N];
    int again [N];
    int waitc [N];
    bit gseen [N];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    // Reference: one grant per window in ptr order; beats at fixed offsets
    task automatic model();
        int g;
        int idx;
        logic [N-1:0] eg;
        beat_t b;
        if (post_rst) chk("addr_after_rst", 32'(ram_rd_addr), 0);
        g  = -1;
        eg = '0;
        if (!rst && busy_until <= cyc) begin
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(eg));
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            b = aq.pop_front();
            chk("ram_rd_addr", 32'(ram_rd_addr), b.addr);
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            b = rq.pop_front();
            chk("resp_valid", 32'(resp_valid), 32'(1) << b.own);
            chk("resp_last", 32'(resp_last), 32'(b.last));
            chk("resp_data", 32'(resp_data), 32'(mem[b.addr]));
        end else begin
            chk("resp_idle_valid", 32'(resp_valid), 0);
            chk("resp_idle_last", 32'(resp_last), 0);
        end
        if (|req_ready) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    chk("fair_wait", 32'(waitc[i] <= N - 1), 1);
                    waitc[i] = 0;
                end else if (req_valid[i]) begin
                    waitc[i]++;
                end
            end
        end
        if (rst) begin
            aq.delete();
            rq.delete();
            mptr = 0;
            busy_until = -1;
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else if (g >= 0) begin
            for (int j = 0; j <= plen[g]; j++) begin
                b.own  = g;
                b.addr = (paddr[g] + j) % DN;
                b.last = (j == plen[g]);
                b.cyc  = cyc + 1 + j;
                aq.push_back(b);
                b.cyc  = cyc + 2 + j;
                rq.push_back(b);
            end
            mptr = (g + 1) % N;
            busy_until = cyc + 1 + plen[g];
            gseen[g] = 1'b1;
        end
        post_rst = rst;
    endtask

    task automatic new_req(input int i);
        pend[i]  = 1'b1;
        paddr[i] = $urandom_range(DN - 1);
        plen[i]  = $urandom_range(len_max);
    endtask

    task automatic set_req(input int i, input int a, input int l);
        pend[i]  = 1'b1;
        paddr[i] = a;
        plen[i]  = l;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_addr[i*AB +: AB] = AB'(paddr[i]);
            req_len[i*LB +: LB]  = LB'(plen[i]);
        end
    endtask

    task automatic agent();
        for (int i = 0; i < N; i++) begin
            if (gseen[i]) begin
                gseen[i] = 1'b0;
                pend[i]  = 1'b0;
                if (again[i] > 0) begin
                    again[i]--;
                    new_req(i);
                end
            end
            if (soak && !pend[i] && $urandom_range(2) == 0) new_req(i);
        end
    endtask

    task automatic step();
        @(negedge rd_clk);
        cyc++;
        model();
        @(posedge rd_clk);
        #1;
        agent();
        drive();
    endtask

    function automatic bit busy();
        bit b;
        b = (aq.size() > 0) || (rq.size() > 0);
        for (int i = 0; i < N; i++) b = b || pend[i] || (again[i] > 0);
        return b;
    endfunction

    task automatic drain(input string tag, input int maxc);
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            step();
            n++;
        end
        chk(tag, 32'(n < maxc), 1);
    endtask

    initial begin
        for (int i = 0; i < DN; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; paddr[i] = 0; plen[i] = 0;
            again[i] = 0; waitc[i] = 0; gseen[i] = 0;
        end
        rst = 1'b1;
        drive();
        repeat (3) step();
        rst = 1'b0;
        step();

        set_req(0, 3, 2);
        drive();
        drain("single_done", 30);

        set_req(1, 10, 3);
        drive();
        drain("wrap_done", 30);

        set_req(1, 5, 3);
        drive();
        step();
        set_req(2, 8, 1);
        drive();
        drain("b2b_done", 30);

        set_req(2, 4, 5);
        drive();
        repeat (3) step();
        rst = 1'b1;
        set_req(0, 7, 1);
        set_req(3, 2, 0);
        drive();
        step();
        rst = 1'b0;
        drain("rst_mid_done", 40);

        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, $urandom_range(DN - 1), 0);
        again[0] = 1;
        drive();
        repeat (2) step();
        rst = 1'b0;
        drain("contend_done", 40);

        len_max = 7;
        soak = 1'b1;
        repeat (400) step();
        soak = 1'b0;
        drain("soak_done", 200);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
